// File: rtl/core_pkg.sv
//==============================================================
// core_pkg - shared RV32I/Zicsr encodings for the core. Rev 1.0
//==============================================================
`default_nettype none

package core_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;

  localparam logic [2:0] F3_PRIV = 3'b000;
  localparam logic [2:0] F3_RSVD = 3'b100;

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;
  localparam logic [11:0] MTVAL   = 12'h343;
  localparam logic [11:0] MHARTID = 12'hF14;

  localparam logic [11:0] IMM_ECALL  = 12'h000;
  localparam logic [11:0] IMM_EBREAK = 12'h001;
  localparam logic [11:0] IMM_MRET   = 12'h302;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;

endpackage

`default_nettype wire

// File: rtl/core_if.sv
//==============================================================
// core_if - fetch/data bus between the core and its memory. Rev 1.0
//==============================================================
`default_nettype none

interface core_if;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic [31:0] data_addr;
  logic [31:0] data_rdata;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;

  modport master (
    output fetch_addr, data_addr, data_wdata, data_wstrb,
    input  fetch_data, data_rdata
  );

  modport slave (
    input  fetch_addr, data_addr, data_wdata, data_wstrb,
    output fetch_data, data_rdata
  );
endinterface

`default_nettype wire

// File: rtl/core_memory.sv
//==============================================================
// core_memory - byte array, two async read ports, one strobed write. Rev 1.0
//==============================================================
`default_nettype none

module core_memory #(
  parameter int MEM_BYTES = 65536
) (
  input logic   clk,
  core_if.slave bus
);
  // MEM_BYTES is a power of two, so truncating the address gives the wrap.
  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    m [0:MEM_BYTES-1];
  logic [AW-1:0] fidx [4];
  logic [AW-1:0] didx [4];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign fidx[i] = AW'(bus.fetch_addr + 32'(i));
    assign didx[i] = AW'(bus.data_addr + 32'(i));
    assign bus.fetch_data[8*i +: 8] = m[fidx[i]];
    assign bus.data_rdata[8*i +: 8] = m[didx[i]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.data_wstrb[i]) m[didx[i]] <= bus.data_wdata[8*i +: 8];
    end
  end
endmodule

`default_nettype wire

// File: rtl/core.sv
//==============================================================
// core - single-cycle RV32I + Zicsr machine-mode CPU. Rev 1.0
//==============================================================
`default_nettype none

module core
  import core_pkg::*;
#(
  parameter int          MEM_BYTES = 65536,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic rst
);
  core_if mem_bus ();
  core_memory #(.MEM_BYTES(MEM_BYTES)) memory (.clk(clk), .bus(mem_bus.slave));

  logic [31:0] pc;
  logic [31:0] rs  [0:31];
  logic [31:0] csr [0:4095];

  logic [31:0] instr, rv1, rv2, csr_old;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [11:0] csr_addr;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign mem_bus.fetch_addr = pc;
  assign instr    = mem_bus.fetch_data;
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign f3       = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign csr_addr = instr[31:20];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'd0};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign rv1      = (rs1 == 5'd0) ? 32'd0 : rs[rs1];
  assign rv2      = (rs2 == 5'd0) ? 32'd0 : rs[rs2];
  assign csr_old  = csr[csr_addr];

  logic [31:0] alu_b, alu_out, sra_out;
  logic [4:0]  shamt;

  assign alu_b   = (opcode == OP) ? rv2 : imm_i;
  assign shamt   = alu_b[4:0];
  assign sra_out = $signed(rv1) >>> shamt;

  always_comb begin
    alu_out = 32'd0;
    case (f3)
      F3_ADD:  alu_out = (opcode == OP && instr[30]) ? rv1 - alu_b : rv1 + alu_b;
      F3_SLL:  alu_out = rv1 << shamt;
      F3_SLT:  alu_out = {31'd0, $signed(rv1) < $signed(alu_b)};
      F3_SLTU: alu_out = {31'd0, rv1 < alu_b};
      F3_XOR:  alu_out = rv1 ^ alu_b;
      F3_SR:   alu_out = instr[30] ? sra_out : rv1 >> shamt;
      F3_OR:   alu_out = rv1 | alu_b;
      F3_AND:  alu_out = rv1 & alu_b;
      default: alu_out = 32'd0;
    endcase
  end

  logic [31:0] next_pc, rd_val, data_addr, csr_wval, csr_src, cause;
  logic [31:0] rdata, trap_status, mret_status;
  logic [3:0]  wstrb;
  logic        rd_we, csr_we, trap, mret, taken;

  assign rdata = mem_bus.data_rdata;

  always_comb begin
    next_pc   = pc + 32'd4;
    rd_we     = 1'b0;
    rd_val    = alu_out;
    data_addr = rv1 + imm_i;
    wstrb     = 4'b0000;
    csr_we    = 1'b0;
    csr_src   = f3[2] ? {27'd0, rs1} : rv1;
    csr_wval  = csr_old;
    trap      = 1'b0;
    cause     = CAUSE_ILLEGAL;
    mret      = 1'b0;
    taken     = 1'b0;

    case (opcode)
      LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
      AUIPC: begin rd_we = 1'b1; rd_val = pc + imm_u; end
      JAL: begin
        rd_we = 1'b1; rd_val = pc + 32'd4; next_pc = pc + imm_j;
      end
      JALR: begin
        rd_we = 1'b1; rd_val = pc + 32'd4; next_pc = (rv1 + imm_i) & ~32'd1;
      end
      BRANCH: begin
        case (f3)
          F3_BEQ:  taken = (rv1 == rv2);
          F3_BNE:  taken = (rv1 != rv2);
          F3_BLT:  taken = ($signed(rv1) < $signed(rv2));
          F3_BGE:  taken = ($signed(rv1) >= $signed(rv2));
          F3_BLTU: taken = (rv1 < rv2);
          F3_BGEU: taken = (rv1 >= rv2);
          default: trap = 1'b1;
        endcase
        if (taken) next_pc = pc + imm_b;
      end
      LOAD: begin
        rd_we = 1'b1;
        case (f3)
          F3_LB:   rd_val = {{24{rdata[7]}}, rdata[7:0]};
          F3_LH:   rd_val = {{16{rdata[15]}}, rdata[15:0]};
          F3_LW:   rd_val = rdata;
          F3_LBU:  rd_val = {24'd0, rdata[7:0]};
          F3_LHU:  rd_val = {16'd0, rdata[15:0]};
          default: trap = 1'b1;
        endcase
      end
      STORE: begin
        data_addr = rv1 + imm_s;
        case (f3)
          F3_SB:   wstrb = 4'b0001;
          F3_SH:   wstrb = 4'b0011;
          F3_SW:   wstrb = 4'b1111;
          default: trap = 1'b1;
        endcase
      end
      OP_IMM, OP: rd_we = 1'b1;
      MISC_MEM: ;
      SYSTEM: begin
        case (f3)
          F3_PRIV: begin
            case (csr_addr)
              IMM_ECALL:  begin trap = 1'b1; cause = CAUSE_ECALL_M; end
              IMM_EBREAK: begin trap = 1'b1; cause = CAUSE_BREAKPOINT; end
              IMM_MRET:   begin mret = 1'b1; next_pc = csr[MEPC]; end
              default: ;
            endcase
          end
          F3_RSVD: trap = 1'b1;
          default: begin
            rd_we  = 1'b1;
            rd_val = csr_old;
            case (f3[1:0])
              2'b01:   begin csr_we = 1'b1; csr_wval = csr_src; end
              2'b10:   begin csr_we = (rs1 != 5'd0); csr_wval = csr_old | csr_src; end
              default: begin csr_we = (rs1 != 5'd0); csr_wval = csr_old & ~csr_src; end
            endcase
            // The 0xC00-0xFFF block (mhartid among it) is read-only.
            if (csr_addr[11:10] == MHARTID[11:10]) csr_we = 1'b0;
          end
        endcase
      end
      default: trap = 1'b1;
    endcase

    if (trap) begin
      next_pc = {csr[MTVEC][31:2], 2'b00};
      rd_we   = 1'b0;
      wstrb   = 4'b0000;
      csr_we  = 1'b0;
    end
  end

  always_comb begin
    trap_status                = csr[MSTATUS];
    trap_status[MPIE_BIT]      = csr[MSTATUS][MIE_BIT];
    trap_status[MIE_BIT]       = 1'b0;
    trap_status[12:11]         = 2'b11;
    mret_status                = csr[MSTATUS];
    mret_status[MIE_BIT]       = csr[MSTATUS][MPIE_BIT];
    mret_status[MPIE_BIT]      = 1'b1;
  end

  assign mem_bus.data_addr  = data_addr;
  assign mem_bus.data_wdata = rv2;
  // A store coinciding with reset must not reach memory.
  assign mem_bus.data_wstrb = rst ? 4'b0000 : wstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) rs[i] <= 32'd0;
      for (int i = 0; i < 4096; i++) csr[i] <= 32'd0;
    end else begin
      pc <= next_pc;
      if (rd_we && rd != 5'd0) rs[rd] <= rd_val;
      if (trap) begin
        csr[MEPC]    <= pc;
        csr[MCAUSE]  <= cause;
        csr[MSTATUS] <= trap_status;
        if (cause == CAUSE_ILLEGAL) csr[MTVAL] <= instr;
      end else if (mret) begin
        csr[MSTATUS] <= mret_status;
      end else if (csr_we) begin
        csr[csr_addr] <= csr_wval;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_core.sv
//==============================================================
// tb_core - directed programs with hand-computed results for core. Rev 1.0
//==============================================================
`default_nettype none

module tb_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  core #(.MEM_BYTES(65536), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst));

  core_if probe ();
  assign probe.fetch_addr = dut.mem_bus.fetch_addr;
  assign probe.fetch_data = dut.mem_bus.fetch_data;
  assign probe.data_addr  = dut.mem_bus.data_addr;
  assign probe.data_rdata = dut.mem_bus.data_rdata;
  assign probe.data_wdata = dut.mem_bus.data_wdata;
  assign probe.data_wstrb = dut.mem_bus.data_wstrb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] e_addi(input int rd, input int r1, input int imm);
    return {12'(imm), 5'(r1), 3'd0, 5'(rd), 7'h13};
  endfunction
  function automatic logic [31:0] e_ld(input int f3, input int rd, input int r1, input int imm);
    return {12'(imm), 5'(r1), 3'(f3), 5'(rd), 7'h03};
  endfunction
  function automatic logic [31:0] e_st(input int f3, input int r2, input int r1, input int imm);
    logic [11:0] v;
    v = 12'(imm);
    return {v[11:5], 5'(r2), 5'(r1), 3'(f3), v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_br(input int f3, input int r1, input int r2, input int off);
    logic [12:0] v;
    v = 13'(off);
    return {v[12], v[10:5], 5'(r2), 5'(r1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] e_jal(input int rd, input int off);
    logic [20:0] v;
    v = 21'(off);
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction
  function automatic logic [31:0] e_jalr(input int rd, input int r1, input int imm);
    return {12'(imm), 5'(r1), 3'd0, 5'(rd), 7'h67};
  endfunction
  function automatic logic [31:0] e_lui(input int rd, input logic [31:0] v);
    return {v[31:12], 5'(rd), 7'h37};
  endfunction
  function automatic logic [31:0] e_rop(input int f7, input int f3, input int rd, input int r1, input int r2);
    return {7'(f7), 5'(r2), 5'(r1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] e_csr(input int f3, input int rd, input int addr, input int r1);
    return {12'(addr), 5'(r1), 3'(f3), 5'(rd), 7'h73};
  endfunction

  localparam logic [31:0] ECALL   = 32'h0000_0073;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;
  localparam logic [31:0] MRET    = 32'h3020_0073;

  task automatic put(input int addr, input logic [31:0] w);
    for (int b = 0; b < 4; b++) dut.memory.m[addr + b] = w[8*b +: 8];
  endtask

  function automatic logic [31:0] peek(input int addr);
    return {dut.memory.m[addr+3], dut.memory.m[addr+2], dut.memory.m[addr+1], dut.memory.m[addr]};
  endfunction

  // Hold reset across an edge, clear memory, then the caller loads a program.
  task automatic begin_load();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 65536; i++) dut.memory.m[i] = 8'h00;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_ldst();
    put(32'h00, e_lui(1, 32'h8040_2000));
    put(32'h04, e_addi(1, 1, 32'h010));
    put(32'h08, e_lui(2, 32'h0000_1000));
    put(32'h0C, e_st(2, 1, 2, 0));
    put(32'h10, e_ld(0, 3, 2, 0));
    put(32'h14, e_ld(4, 4, 2, 3));
    put(32'h18, e_ld(1, 5, 2, 2));
    put(32'h1C, e_ld(5, 6, 2, 2));
    put(32'h20, e_ld(2, 7, 2, 1));
    put(32'h24, e_st(1, 1, 2, 3));
    put(32'h28, e_ld(2, 8, 2, 0));
    put(32'h2C, e_ld(2, 9, 0, -2));
    put(32'h30, e_jal(0, 0));
  endtask

  task automatic check_ldst(input string sfx);
    check({"pc_end", sfx}, dut.pc, 32'h30);
    check({"lb", sfx},     dut.rs[3], 32'h0000_0010);
    check({"lbu", sfx},    dut.rs[4], 32'h0000_0080);
    check({"lh", sfx},     dut.rs[5], 32'hFFFF_8040);
    check({"lhu", sfx},    dut.rs[6], 32'h0000_8040);
    check({"lw_mis", sfx}, dut.rs[7], 32'h0080_4020);
    check({"sh_mis", sfx}, dut.rs[8], 32'h1040_2010);
    check({"lw_wrap", sfx}, dut.rs[9], 32'h20B7_0000);
  endtask

  initial begin
    logic [31:0] acc;

    // Pass-convention loop
    begin_load();
    put(32'h00, e_addi(3, 0, 1));
    put(32'h04, e_jal(0, 32'h40));
    put(32'h44, e_jal(0, 0));
    #1;
    check("rst_pc", dut.pc, 32'h0);
    check("rst_x3", dut.rs[3], 32'h0);
    check("rst_fetch", probe.fetch_data, 32'h0010_0193);
    release_rst();
    run(3);
    check("pass_pc", dut.pc, 32'h44);
    check("pass_x3", dut.rs[3], 32'h1);
    run(5);
    check("pass_hold", dut.pc, 32'h44);

    // EBREAK / MRET
    begin_load();
    put(32'h000, e_addi(1, 0, 32'h100));
    put(32'h004, e_csr(1, 0, 32'h305, 1));
    put(32'h008, e_jal(0, 32'h18));
    put(32'h020, EBREAK);
    put(32'h100, MRET);
    release_rst();
    run(3);
    check("brk_pre_pc", dut.pc, 32'h20);
    run(1);
    check("brk_pc", dut.pc, 32'h100);
    check("brk_mepc", dut.csr[12'h341], 32'h20);
    check("brk_mcause", dut.csr[12'h342], 32'd3);
    check("brk_mpp", {30'd0, dut.csr[12'h300][12:11]}, 32'd3);
    check("brk_mstatus", dut.csr[12'h300], 32'h0000_1800);
    run(1);
    check("mret_pc", dut.pc, 32'h20);
    check("mret_mstatus", dut.csr[12'h300], 32'h0000_1880);

    // ECALL, x0, CSR read-only and set-with-x0, illegal opcode
    begin_load();
    put(32'h000, e_addi(1, 0, 32'h200));
    put(32'h004, e_csr(1, 0, 32'h305, 1));
    put(32'h008, e_addi(0, 0, 5));
    put(32'h00C, e_addi(7, 0, 32'h55));
    put(32'h010, e_csr(2, 8, 32'h305, 0));
    put(32'h014, e_csr(1, 9, 32'hF14, 1));
    put(32'h018, e_jal(0, 32'h18));
    put(32'h030, ECALL);
    put(32'h200, 32'hFFFF_FFFF);
    release_rst();
    run(8);
    check("ecall_pc", dut.pc, 32'h200);
    check("ecall_mcause", dut.csr[12'h342], 32'd11);
    check("ecall_mepc", dut.csr[12'h341], 32'h30);
    check("x0_zero", dut.rs[0], 32'h0);
    check("ecall_x7", dut.rs[7], 32'h55);
    check("csrrs_x0_rd", dut.rs[8], 32'h200);
    check("mtvec_kept", dut.csr[12'h305], 32'h200);
    check("mhartid_rd", dut.rs[9], 32'h0);
    check("mhartid_ro", dut.csr[12'hF14], 32'h0);
    run(1);
    check("ill_pc", dut.pc, 32'h200);
    check("ill_mcause", dut.csr[12'h342], 32'd2);
    check("ill_mtval", dut.csr[12'h343], 32'hFFFF_FFFF);
    check("ill_mepc", dut.csr[12'h341], 32'h200);

    // Loads and stores, including misaligned and wrapped addresses
    begin_load();
    load_ldst();
    release_rst();
    run(15);
    check_ldst("");

    // Branches, ALU, JALR
    begin_load();
    put(32'h00, e_addi(1, 0, -1));
    put(32'h04, e_addi(2, 0, 1));
    put(32'h08, e_br(4, 1, 2, 8));
    put(32'h0C, e_addi(10, 0, 1));
    put(32'h10, e_br(6, 1, 2, 8));
    put(32'h14, e_addi(11, 0, 1));
    put(32'h18, e_lui(3, 32'h8000_0000));
    put(32'h1C, e_addi(4, 0, 4));
    put(32'h20, e_rop(32'h20, 5, 5, 3, 4));
    put(32'h24, e_addi(6, 0, 32'h31));
    put(32'h28, e_jalr(7, 6, 0));
    put(32'h2C, e_addi(12, 0, 1));
    put(32'h30, e_rop(32'h20, 0, 13, 2, 1));
    put(32'h34, e_jal(0, 0));
    release_rst();
    run(14);
    check("alu_pc", dut.pc, 32'h34);
    check("blt_taken", dut.rs[10], 32'h0);
    check("bltu_not", dut.rs[11], 32'h1);
    check("sra", dut.rs[5], 32'hF800_0000);
    check("jalr_link", dut.rs[7], 32'h2C);
    check("jalr_skip", dut.rs[12], 32'h0);
    check("sub", dut.rs[13], 32'h2);

    // Asynchronous reset in the middle of the load/store program
    begin_load();
    load_ldst();
    release_rst();
    run(6);
    check("pre_rst_x1", dut.rs[1], 32'h8040_2010);
    #2;
    rst = 1'b1;
    #1;
    check("async_pc", dut.pc, 32'h0);
    acc = 32'd0;
    for (int i = 0; i < 32; i++) acc = acc | dut.rs[i];
    check("async_rs", acc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("img_w0", peek(32'h00), e_lui(1, 32'h8040_2000));
    check("img_w9", peek(32'h24), e_st(1, 1, 2, 3));
    rst = 1'b0;
    run(15);
    check_ldst("_rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
